regfile: RTL and testbench

Architectural register file for the combined ARM/RISC-V pipeline. It is the consumer end of the writeback interface: it accepts RdW/ResultW/RegWriteW from the W stage and serves two combinational read ports to the decode stage. In RV mode it holds x0..x31 with x0 hardwired to zero. In ARM mode it holds R0..R14 and synthesises R15 reads from the decode-stage PC+8.

---
 rtl/combi_pkg.sv | 23 ++
 rtl/regfile_rdport.sv | 45 ++++
 rtl/regfile.sv | 59 +++++
 tb/tb_regfile.sv | 128 ++++++++++++
 4 files changed

// File: rtl/combi_pkg.sv
// Shared constants and address-decode helpers for the ARM/RISC-V register file
// and the hazard unit.
package combi_pkg;

  localparam int RV_ZERO_IDX = 0;
  localparam int ARM_PC_IDX  = 15;
  localparam int ARM_ADDR_W  = 4;
  localparam int RV_ADDR_W   = 5;

  // True when a write to addr may land in storage: never x0 in RV, never R15 in ARM.
  function automatic logic writable(input logic arm, input logic [RV_ADDR_W-1:0] addr);
    if (arm) return addr[ARM_ADDR_W-1:0] != ARM_ADDR_W'(ARM_PC_IDX);
    else     return addr != RV_ADDR_W'(RV_ZERO_IDX);
  endfunction

  // Physical entry selected by an architectural address; ARM ignores bit 4.
  function automatic logic [RV_ADDR_W-1:0] entry_idx(input logic arm,
                                                     input logic [RV_ADDR_W-1:0] addr);
    if (arm) return RV_ADDR_W'(addr[ARM_ADDR_W-1:0]);
    else     return addr;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: x0/R15 decode and, with REGFILE_BYPASS_EN defined,
// write-through of the in-flight writeback data.
module regfile_rdport
  import combi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic [RV_ADDR_W-1:0]        addr,
  input  logic                        arm,
  input  logic [WIDTH-1:0]            r15,
  input  logic                        we,
  input  logic [RV_ADDR_W-1:0]        wa,
  input  logic [WIDTH-1:0]            wd,
  output logic [WIDTH-1:0]            rd
);

  logic [RV_ADDR_W-1:0] idx;
  logic                 in_range;

  assign idx      = entry_idx(arm, addr);
  assign in_range = 32'(idx) < NREGS;

  always_comb begin
    rd = '0;
    if (arm && idx == RV_ADDR_W'(ARM_PC_IDX)) begin
      rd = r15;
    end else if (!arm && idx == RV_ADDR_W'(RV_ZERO_IDX)) begin
      rd = '0;
    end else if (in_range) begin
      rd = regs[idx];
`ifdef REGFILE_BYPASS_EN
      // x0/R15 are already excluded by writable() and the branches above.
      if (we && writable(arm, wa) && entry_idx(arm, wa) == idx) rd = wd;
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{we, wa, wd};
`endif

endmodule

// File: rtl/regfile.sv
// Architectural register file, RV x0..x31 / ARM R0..R15, two combinational reads.
// Optional same-cycle write-through bypass under REGFILE_BYPASS_EN.
module regfile
  import combi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 we3,
  input  logic [4:0]           a3,
  input  logic [WIDTH-1:0]     wd3,
  input  logic [4:0]           a1,
  input  logic [4:0]           a2,
  input  logic [WIDTH-1:0]     r15,
  output logic [WIDTH-1:0]     rd1,
  output logic [WIDTH-1:0]     rd2
);

  localparam int NPORTS = 2;

  logic [NREGS-1:0][WIDTH-1:0]      regs;
  logic [RV_ADDR_W-1:0]             widx;
  logic                             wen;
  logic                             byp_we;
  logic [NPORTS-1:0][RV_ADDR_W-1:0] raddr;
  logic [NPORTS-1:0][WIDTH-1:0]     rdata;

  assign widx = entry_idx(arm, a3);
  assign wen  = we3 && writable(arm, a3) && (32'(widx) < NREGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      regs       <= '0;
    else if (wen) regs[widx] <= wd3;
  end

  // Reset must also suppress the bypass so reads show 0 while rst is high.
  assign byp_we = we3 && !rst;
  assign raddr  = {a2, a1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    regfile_rdport #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd (
      .regs (regs),
      .addr (raddr[p]),
      .arm  (arm),
      .r15  (r15),
      .we   (byp_we),
      .wa   (a3),
      .wd   (wd3),
      .rd   (rdata[p])
    );
  end

  assign rd1 = rdata[0];
  assign rd2 = rdata[1];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: vector table plus reset and bypass sequences.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        we3;
  logic [4:0]  a3, a1, a2;
  logic [31:0] wd3, r15, rd1, rd2;

  int n_vec = 0;
  int n_err = 0;

  regfile #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .arm(arm), .we3(we3), .a3(a3), .wd3(wd3),
    .a1(a1), .a2(a2), .r15(r15), .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] r15;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            arm   we    a3     wd3           a1     a2     r15           e1            e2
    vecs[0]  = '{1'b0, 1'b1, 5'd7,  32'h12345678, 5'd0,  5'd1,  32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd0,  32'h0,        32'h12345678, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h0,        32'h12345678};
    vecs[3]  = '{1'b1, 1'b1, 5'h13, 32'h55,       5'd15, 5'd7,  32'h1008,     32'h1008,     32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd3,  5'h13, 32'h1008,     32'h55,       32'h55};
    vecs[5]  = '{1'b1, 1'b1, 5'd15, 32'hAAAA,     5'd15, 5'h1F, 32'h1008,     32'h1008,     32'h1008};
    vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd15, 5'h0F, 32'h2000,     32'h2000,     32'h2000};
    vecs[7]  = '{1'b1, 1'b1, 5'd4,  32'h44,       5'd3,  5'd0,  32'h2000,     32'h55,       32'h0};
    vecs[8]  = '{1'b0, 1'b1, 5'd20, 32'h77,       5'd15, 5'd3,  32'h2000,     32'h0,        32'h55};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd20, 5'd7,  32'h2000,     32'h44,       32'h12345678};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd20, 5'd19, 32'h2000,     32'h77,       32'h0};
    vecs[11] = '{1'b0, 1'b1, 5'd31, 32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 5'h10, 32'hA0,       5'd1,  5'd2,  32'h0,        32'h0,        32'h0};
    vecs[14] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'h10, 32'h0,        32'hA0,       32'hA0};
    vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'h10, 32'h0,        32'h0,        32'h0};
    vecs[16] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd4,  5'h1F, 32'hFFFF0000, 32'h44,       32'hFFFF0000};

    rst = 1'b1; arm = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0; a1 = 5'd5; a2 = 5'd0; r15 = '0;

    // Reset state, then async reset colliding with a write.
    @(negedge clk);
    check("rst_state_rd1", rd1, 32'h0);
    check("rst_state_rd2", rd2, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h5555; a1 = 5'd0;
    @(posedge clk); #1;
    we3 = 1'b0;
    a1 = 5'd5;
    @(negedge clk);
    check("x5_write", rd1, 32'h5555);
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD;
    #1 rst = 1'b1;
    #1 check("rst_async", rd1, 32'h0);
    @(posedge clk); #1;
    check("rst_hold", rd1, 32'h0);
    @(negedge clk);
    rst = 1'b0; we3 = 1'b0;
    #1 check("rst_release", rd1, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      arm = vecs[i].arm; we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      a1 = vecs[i].a1; a2 = vecs[i].a2; r15 = vecs[i].r15;
      @(negedge clk);
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
    end

    // Same-cycle read of an entry being written.
    @(posedge clk); #1;
    arm = 1'b0; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h1111; a1 = 5'd0; a2 = 5'd0;
    @(posedge clk); #1;
    wd3 = 32'hCAFE; a1 = 5'd9; a2 = 5'd9;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("byp_same_rd1", rd1, 32'hCAFE);
    check("byp_same_rd2", rd2, 32'hCAFE);
`else
    check("byp_same_rd1", rd1, 32'h1111);
    check("byp_same_rd2", rd2, 32'h1111);
`endif
    @(posedge clk); #1;
    we3 = 1'b0;
    @(negedge clk);
    check("byp_next_rd1", rd1, 32'hCAFE);

    // Write to x0 in the same cycle as reading x0, and to R15 while reading R15.
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a1 = 5'd0;
    #1 check("byp_x0", rd1, 32'h0);
    arm = 1'b1; a3 = 5'd15; wd3 = 32'hAAAA; a1 = 5'd15; r15 = 32'h1008;
    #1 check("byp_r15", rd1, 32'h1008);
    @(posedge clk); #1;
    we3 = 1'b0; arm = 1'b0; a1 = 5'd15;
    @(negedge clk);
    check("r15_store_untouched", rd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
